// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue block: opcodes, default width, FSM encoding.
package alu_issue_pkg;

    localparam int WIDTH_DEF = 10;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_NAND = 2'd2,
        ALU_SLT  = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_if.sv
// Command/result handshake bundle between a command source/result sink and alu_issue.
interface alu_issue_if #(parameter int WIDTH = alu_issue_pkg::WIDTH_DEF);
    import alu_issue_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    alu_op_e          cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_chain;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic [7:0]       op_count;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, res_ready,
        input  cmd_ready, res_valid, res_data, res_zero, op_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, res_ready,
        output cmd_ready, res_valid, res_data, res_zero, op_count
    );

endinterface

// File: rtl/alu_issue_alu.sv
// Combinational ALU: add, subtract, nand and signed set-less-than, all modulo 2^WIDTH.
module alu
    import alu_issue_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] dataout
);

    always_comb begin
        dataout = '0;
        case (op)
            ALU_ADD:  dataout = a + b;
            ALU_SUB:  dataout = a - b;
            ALU_NAND: dataout = ~(a & b);
            ALU_SLT:  dataout = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default:  dataout = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Single-outstanding ALU issue stage: accept in IDLE, compute in EXEC, present in HOLD.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    alu_issue_if.slave  bus
);

    state_e           state_q, state_d;
    alu_op_e          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_zero_q, res_zero_d;
    logic [7:0]       op_count_q, op_count_d;
    logic [WIDTH-1:0] chain_q, chain_d;
    logic [WIDTH-1:0] alu_out;

    alu #(.WIDTH(WIDTH)) u_alu (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .dataout (alu_out)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        res_data_d = res_data_q;
        res_zero_d = res_zero_q;
        op_count_d = op_count_q;
        chain_d    = chain_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    // Chained commands take A from the last result the sink accepted.
                    a_d     = bus.cmd_chain ? chain_q : bus.cmd_a;
                    b_d     = bus.cmd_b;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_data_d = alu_out;
                res_zero_d = (alu_out == '0);
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.res_ready) begin
                    chain_d    = res_data_q;
                    op_count_d = op_count_q + 8'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= ALU_ADD;
            a_q        <= '0;
            b_q        <= '0;
            res_data_q <= '0;
            res_zero_q <= 1'b1;
            op_count_q <= '0;
            chain_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_data_q <= res_data_d;
            res_zero_q <= res_zero_d;
            op_count_q <= op_count_d;
            chain_q    <= chain_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.res_valid = (state_q == ST_HOLD);
    assign bus.res_data  = res_data_q;
    assign bus.res_zero  = res_zero_q;
    assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: latency, wrap, chaining, back-pressure, reset and count wrap.
module tb_alu_issue;
    import alu_issue_pkg::*;

    localparam int W = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_tot  = 0;

    alu_issue_if #(.WIDTH(W)) bus ();

    alu_issue #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot = n_tot + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one command from IDLE and leaves the block in HOLD.
    task automatic issue(input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic chain, input bit chk);
        if (chk) check("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_chain = chain;
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_chain = 1'b0;
        if (chk) check("lat_exec_no_valid", {31'd0, bus.res_valid}, 32'd0);
        step();
        if (chk) check("lat_hold_valid", {31'd0, bus.res_valid}, 32'd1);
    endtask

    task automatic deliver();
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = ALU_ADD;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_chain = 1'b0;
        bus.res_ready = 1'b0;
        step();
        step();

        // Test 1: reset state, then a first command right after release
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_res_zero",  {31'd0, bus.res_zero},  32'd1);
        check("rst_res_data",  {22'd0, bus.res_data},  32'd0);
        check("rst_op_count",  {24'd0, bus.op_count},  32'd0);
        reset = 1'b0;
        issue(ALU_ADD, 10'h3F0, 10'h00F, 1'b0, 1'b1);
        check("t1_data", {22'd0, bus.res_data}, 32'h3FF);
        check("t1_zero", {31'd0, bus.res_zero}, 32'd0);
        deliver();
        check("t1_count", {24'd0, bus.op_count}, 32'd1);
        check("t1_idle",  {31'd0, bus.cmd_ready}, 32'd1);

        // Test 2: modular wrap in both directions, plus nand
        issue(ALU_ADD, 10'h3FF, 10'h3FF, 1'b0, 1'b1);
        check("t2_add_wrap", {22'd0, bus.res_data}, 32'h3FE);
        deliver();
        issue(ALU_SUB, 10'h000, 10'h00F, 1'b0, 1'b1);
        check("t2_sub_wrap", {22'd0, bus.res_data}, 32'h3F1);
        deliver();
        issue(ALU_NAND, 10'h3F0, 10'h0FF, 1'b0, 1'b1);
        check("t2_nand", {22'd0, bus.res_data}, 32'h30F);
        deliver();

        // Test 3: chained subtract ignores cmd_a
        issue(ALU_ADD, 10'h3F0, 10'h00F, 1'b0, 1'b0);
        deliver();
        issue(ALU_SUB, 10'h123, 10'h3FF, 1'b1, 1'b1);
        check("t3_chain_data", {22'd0, bus.res_data}, 32'h000);
        check("t3_chain_zero", {31'd0, bus.res_zero}, 32'd1);
        deliver();
        check("t3_count", {24'd0, bus.op_count}, 32'd6);

        // Test 4: back-pressure in HOLD while the command side churns
        issue(ALU_ADD, 10'h100, 10'h023, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = i[0];
            bus.cmd_op    = alu_op_e'(i[1:0]);
            bus.cmd_a     = 10'(i * 37);
            bus.cmd_b     = 10'(i * 91);
            step();
            check("t4_hold_data",  {22'd0, bus.res_data},  32'h123);
            check("t4_hold_valid", {31'd0, bus.res_valid}, 32'd1);
            check("t4_hold_ready", {31'd0, bus.cmd_ready}, 32'd0);
            check("t4_hold_count", {24'd0, bus.op_count},  32'd6);
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        #1;
        check("t4_no_overlap", {31'd0, bus.cmd_ready}, 32'd0);
        step();
        check("t4_release_count", {24'd0, bus.op_count}, 32'd7);
        check("t4_release_idle",  {31'd0, bus.cmd_ready}, 32'd1);
        step();
        bus.res_ready = 1'b0;
        check("t4_ready_ignored_idle", {24'd0, bus.op_count}, 32'd7);

        // Test 5: reset during EXEC discards the result; chain then starts from 0
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = ALU_ADD;
        bus.cmd_a     = 10'h005;
        bus.cmd_b     = 10'h006;
        step();
        bus.cmd_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("t5_rst_valid", {31'd0, bus.res_valid}, 32'd0);
        check("t5_rst_count", {24'd0, bus.op_count},  32'd0);
        check("t5_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("t5_rst_data",  {22'd0, bus.res_data},  32'd0);
        step();
        reset = 1'b0;
        issue(ALU_SUB, 10'h155, 10'h001, 1'b1, 1'b1);
        check("t5_chain_zero_a", {22'd0, bus.res_data}, 32'h3FF);
        deliver();
        check("t5_count", {24'd0, bus.op_count}, 32'd1);

        // Test 6: op_count wraps after 256 deliveries; signed compare
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            issue(ALU_ADD, 10'(i), 10'h001, 1'b0, 1'b0);
            deliver();
            if (i == 254) check("t6_count_255", {24'd0, bus.op_count}, 32'd255);
        end
        check("t6_count_wrap", {24'd0, bus.op_count}, 32'd0);
        issue(ALU_SLT, 10'h200, 10'h000, 1'b0, 1'b1);
        check("t6_slt_neg", {22'd0, bus.res_data}, 32'h001);
        check("t6_slt_neg_zero", {31'd0, bus.res_zero}, 32'd0);
        deliver();
        issue(ALU_SLT, 10'h000, 10'h200, 1'b0, 1'b1);
        check("t6_slt_pos", {22'd0, bus.res_data}, 32'h000);
        check("t6_slt_pos_zero", {31'd0, bus.res_zero}, 32'd1);
        deliver();
        check("t6_count_after", {24'd0, bus.op_count}, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, giving the datapath width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port cmd_valid, input, 1, asserted when a command is offered.
REQ-005 The block SHALL have port cmd_ready, output, 1, asserted when the block can accept a command.
REQ-006 The block SHALL have port cmd_op, input, 2, ALU operation code per the shared package.
REQ-007 The block SHALL have ports cmd_a and cmd_b, input, WIDTH each, holding the operands.
REQ-008 The block SHALL have port cmd_chain, input, 1; when set, the last delivered result replaces cmd_a.
REQ-009 The block SHALL have port res_valid, output, 1, asserted when a result is presented.
REQ-010 The block SHALL have port res_ready, input, 1, asserted when the sink accepts a result.
REQ-011 The block SHALL have port res_data, output, WIDTH, holding the ALU result.
REQ-012 The block SHALL have port res_zero, output, 1, set when res_data equals 0.
REQ-013 The block SHALL have port op_count, output, 8, counting delivered results modulo 256.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, EXEC and HOLD.
REQ-015 cmd_ready SHALL be 1 only in IDLE.
REQ-016 A command SHALL be accepted on a rising edge with cmd_valid=1 in IDLE; operands and op are then registered and the FSM enters EXEC.
REQ-017 In EXEC, the registered operands SHALL drive the alu sub-module; its dataout SHALL be captured into res_data, res_zero SHALL be computed, and the FSM SHALL enter HOLD.
REQ-018 res_valid SHALL be 1 exactly in HOLD, giving a fixed 2-cycle latency from command acceptance to the first res_valid.
REQ-019 In HOLD, res_data and res_zero SHALL stay stable until a cycle with res_ready=1; on that edge the FSM SHALL return to IDLE and op_count SHALL increment, wrapping 255 to 0.
REQ-020 When a command is accepted with cmd_chain=1, operand A SHALL be the res_data of the last delivered result, and cmd_a SHALL be ignored.
REQ-021 When cmd_chain=1 and no result has been delivered since reset, operand A SHALL be 0.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH; carry and borrow SHALL be discarded.
REQ-023 In HOLD with res_ready=1, cmd_ready SHALL remain 0 (no back-to-back overlap); the next command SHALL be accepted no earlier than the following cycle.
REQ-024 cmd_valid, cmd_op, cmd_a and cmd_b SHALL be ignored outside IDLE.
REQ-025 res_ready SHALL be ignored outside HOLD.

Reset
REQ-026 Asserting reset SHALL immediately force: FSM to IDLE, cmd_ready=1, res_valid=0, res_data=0, res_zero=1, op_count=0, and the chain register to 0.
REQ-027 Reset in EXEC or HOLD SHALL discard the in-flight result without incrementing op_count.
REQ-028 The first command SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-029 A shared package SHALL hold the opcode constants ALU_ADD=0, ALU_SUB=1 (a-b), ALU_NAND=2 and ALU_SLT=3 (signed a<b gives 1, else 0), the WIDTH default, and the FSM state encoding.
REQ-030 The block SHALL instantiate the existing alu module once as its only sub-module; no ALU logic SHALL be duplicated in alu_issue.

Verification
REQ-031 Test 1: after reset, check cmd_ready=1, res_valid=0, res_zero=1 and op_count=0, then issue ADD 0x3F0+0x00F -> res_valid exactly 2 cycles after acceptance, res_data=0x3FF, res_zero=0.
REQ-032 Test 2: issue ADD 0x3FF+0x3FF -> res_data=0x3FE (wrap); then SUB 0x000-0x00F -> res_data=0x3F1.
REQ-033 Test 3: issue ADD 0x3F0+0x00F, deliver it, then chain SUB with cmd_b=0x3FF and cmd_a=0x123 -> res_data=0x000, res_zero=1.
REQ-034 Test 4: hold res_ready=0 for 5 cycles in HOLD while toggling cmd_* -> res_data stable, cmd_ready=0, op_count unchanged; release -> op_count increments by 1.
REQ-035 Test 5: assert reset during EXEC -> res_valid=0, op_count unchanged, and a chain command after release uses A=0 if nothing was delivered before.
REQ-036 Test 6: deliver 256 results -> op_count wraps to 0; also SLT 0x200 vs 0x000 -> res_data=0x001.
